// File: rtl/sign_narrow.sv
// sign_narrow: narrow a signed IN_SIZE value to OUT_SIZE (wrap or saturate)
// into a 2-entry FIFO, plus sticky/counted overflow status.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     input handshake
//   in_data[IN_SIZE]      signed value to narrow
//   sat_en                1 = saturate on overflow, 0 = wrap
//   out_valid/out_ready   output handshake
//   out_data[OUT_SIZE]    narrowed head entry
//   out_ovf               head entry overflowed
//   ovf_clr               clear sticky flag and counter
//   ovf_sticky            any overflow accepted since clear/reset
//   ovf_count[8]          accepted overflows, saturating at 255
module sign_narrow #(
  parameter int IN_SIZE  = 16,
  parameter int OUT_SIZE = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_SIZE-1:0]  in_data,
  input  logic                sat_en,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_SIZE-1:0] out_data,
  output logic                out_ovf,
  input  logic                ovf_clr,
  output logic                ovf_sticky,
  output logic [7:0]          ovf_count
);

  localparam int TW = IN_SIZE - OUT_SIZE + 1;

  logic [OUT_SIZE-1:0] r_data [2];
  logic [1:0]          r_ovf;
  logic [1:0]          r_count;
  logic                r_wr;
  logic                r_rd;
  logic                r_sticky;
  logic [7:0]          r_ocnt;

  logic [TW-1:0]       w_top;
  logic                w_ovf;
  logic                w_neg;
  logic [OUT_SIZE-1:0] w_sat;
  logic [OUT_SIZE-1:0] w_nd;
  logic                w_acc;
  logic                w_con;
  logic                w_acc_ovf;
  logic [1:0]          w_count_nx;

  // The bits from the output sign position up must all match the
  // input sign, otherwise the value does not fit.
  assign w_top = in_data[IN_SIZE-1:OUT_SIZE-1];
  assign w_ovf = ~((&w_top) | ~(|w_top));
  assign w_neg = in_data[IN_SIZE-1];
  assign w_sat = {w_neg, {(OUT_SIZE-1){~w_neg}}};
  assign w_nd  = (w_ovf && sat_en) ? w_sat
                                   : in_data[OUT_SIZE-1:0];

  // in_ready depends on registered count only.
  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_data[r_rd];
  assign out_ovf   = r_ovf[r_rd];

  assign w_acc     = in_valid && in_ready;
  assign w_con     = out_valid && out_ready;
  assign w_acc_ovf = w_acc && w_ovf;

  always_comb begin
    w_count_nx = r_count;
    unique case (1'b1)
      (w_acc && !w_con): w_count_nx = r_count + 2'd1;
      (!w_acc && w_con): w_count_nx = r_count - 2'd1;
      default:           w_count_nx = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data[0] <= '0;
      r_data[1] <= '0;
      r_ovf     <= '0;
      r_count   <= '0;
      r_wr      <= 1'b0;
      r_rd      <= 1'b0;
    end else begin
      r_count <= w_count_nx;
      if (w_acc) begin
        r_data[r_wr] <= w_nd;
        r_ovf[r_wr]  <= w_ovf;
        r_wr         <= ~r_wr;
      end
      if (w_con) begin
        r_rd <= ~r_rd;
      end
    end
  end

  // A clear coinciding with an overflow keeps that overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
      r_ocnt   <= 8'd0;
    end else if (ovf_clr) begin
      r_sticky <= w_acc_ovf;
      r_ocnt   <= {7'd0, w_acc_ovf};
    end else if (w_acc_ovf) begin
      r_sticky <= 1'b1;
      if (r_ocnt != 8'hFF) begin
        r_ocnt <= r_ocnt + 8'd1;
      end
    end
  end

  assign ovf_sticky = r_sticky;
  assign ovf_count  = r_ocnt;

endmodule

// File: tb/tb_sign_narrow.sv
// tb_sign_narrow: table vectors plus scoreboard queue
// and hand sequences for backpressure, clear and reset.
module tb_sign_narrow;

  typedef struct packed {
    logic [7:0] d;
    logic       o;
  } ent_t;

  typedef struct {
    logic [15:0] din;
    logic        sat;
    logic [7:0]  ed;
    logic        eo;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        sat_en;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_ovf;
  logic        ovf_clr;
  logic        ovf_sticky;
  logic [7:0]  ovf_count;

  int   errs = 0;
  int   nchk = 0;
  ent_t sb[$];
  logic [7:0] exp_d;
  logic       exp_o;
  logic       last_acc;
  int         m_cnt;
  logic       m_stk;
  vec_t       tbl [15];

  always #5 clk = ~clk;

  sign_narrow #(.IN_SIZE(16), .OUT_SIZE(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .sat_en(sat_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf),
    .ovf_clr(ovf_clr), .ovf_sticky(ovf_sticky),
    .ovf_count(ovf_count)
  );

  initial begin
    #500000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic void model(input logic [15:0] d,
                                input logic s,
                                output logic [7:0] q,
                                output logic o);
    int v;
    v = int'($signed(d));
    o = (v > 127) || (v < -128);
    if (o && s) q = (v > 127) ? 8'h7F : 8'h80;
    else q = d[7:0];
  endfunction

  // Called just after a negedge with inputs driven.
  task automatic tick();
    logic acc, con, aovf;
    ent_t e;
    #1;
    chk("out_valid", out_valid, sb.size() != 0);
    chk("in_ready", in_ready, sb.size() < 2);
    chk("ovf_count", ovf_count, m_cnt);
    chk("ovf_sticky", ovf_sticky, m_stk);
    if (sb.size() != 0) begin
      chk("out_data", out_data, sb[0].d);
      chk("out_ovf", out_ovf, sb[0].o);
    end
    acc = in_valid && in_ready;
    con = out_valid && out_ready;
    last_acc = acc;
    if (con && sb.size() != 0) e = sb.pop_front();
    if (acc) sb.push_back('{d: exp_d, o: exp_o});
    aovf = acc && exp_o;
    if (ovf_clr) begin
      m_stk = aovf;
      m_cnt = aovf ? 1 : 0;
    end else if (aovf) begin
      m_stk = 1'b1;
      if (m_cnt < 255) m_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic [15:0] d,
                       input logic s,
                       input logic [7:0] ed,
                       input logic eo);
    in_valid = 1'b1;
    in_data  = d;
    sat_en   = s;
    exp_d    = ed;
    exp_o    = eo;
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] q;
    logic o;
    int n;
    tbl[0]  = '{16'h0012, 1'b1, 8'h12, 1'b0};
    tbl[1]  = '{16'hFFF0, 1'b1, 8'hF0, 1'b0};
    tbl[2]  = '{16'h0180, 1'b1, 8'h7F, 1'b1};
    tbl[3]  = '{16'h0180, 1'b0, 8'h80, 1'b1};
    tbl[4]  = '{16'hFE00, 1'b1, 8'h80, 1'b1};
    tbl[5]  = '{16'h007F, 1'b1, 8'h7F, 1'b0};
    tbl[6]  = '{16'hFF80, 1'b1, 8'h80, 1'b0};
    tbl[7]  = '{16'h0080, 1'b1, 8'h7F, 1'b1};
    tbl[8]  = '{16'h0080, 1'b0, 8'h80, 1'b1};
    tbl[9]  = '{16'hFF7F, 1'b1, 8'h80, 1'b1};
    tbl[10] = '{16'hFF7F, 1'b0, 8'h7F, 1'b1};
    tbl[11] = '{16'h8000, 1'b1, 8'h80, 1'b1};
    tbl[12] = '{16'h7FFF, 1'b0, 8'hFF, 1'b1};
    tbl[13] = '{16'h0000, 1'b0, 8'h00, 1'b0};
    tbl[14] = '{16'hFFFF, 1'b1, 8'hFF, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    sat_en = 1'b0;
    out_ready = 1'b1;
    ovf_clr = 1'b0;
    exp_d = '0;
    exp_o = 1'b0;
    m_cnt = 0;
    m_stk = 1'b0;
    #12;
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst out_data", out_data, 0);
    chk("rst out_ovf", out_ovf, 0);
    chk("rst sticky", ovf_sticky, 0);
    chk("rst count", ovf_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      if (i == 5) begin
        chk("cnt after 5", ovf_count, 3);
        chk("stk after 5", ovf_sticky, 1);
      end
      drive(tbl[i].din, tbl[i].sat, tbl[i].ed, tbl[i].eo);
    end
    idle();
    idle();
    chk("cnt table", ovf_count, 9);

    // Backpressure: A,B fill, C waits for in_ready.
    out_ready = 1'b0;
    drive(16'h0001, 1'b1, 8'h01, 1'b0);
    drive(16'h0002, 1'b1, 8'h02, 1'b0);
    n = 0;
    last_acc = 1'b0;
    while (!last_acc && n < 10) begin
      if (n == 1) out_ready = 1'b1;
      drive(16'h0003, 1'b1, 8'h03, 1'b0);
      n++;
    end
    chk("C accept tries", n, 3);
    idle();
    idle();
    idle();

    // 300 overflows, then clear racing an overflow.
    for (int i = 0; i < 300; i++) begin
      model(16'h4000 + 16'(i), 1'b1, q, o);
      drive(16'h4000 + 16'(i), 1'b1, q, o);
    end
    idle();
    chk("cnt sat", ovf_count, 255);
    ovf_clr = 1'b1;
    model(16'hC000, 1'b0, q, o);
    drive(16'hC000, 1'b0, q, o);
    ovf_clr = 1'b0;
    idle();
    chk("cnt clr+ovf", ovf_count, 1);
    chk("stk clr+ovf", ovf_sticky, 1);
    ovf_clr = 1'b1;
    idle();
    ovf_clr = 1'b0;
    idle();
    chk("cnt clr", ovf_count, 0);
    chk("stk clr", ovf_sticky, 0);

    // Mid-cycle reset with two entries buffered.
    out_ready = 1'b0;
    drive(16'h0055, 1'b1, 8'h55, 1'b0);
    model(16'h1234, 1'b1, q, o);
    drive(16'h1234, 1'b1, q, o);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid rst out_valid", out_valid, 0);
    chk("mid rst out_data", out_data, 0);
    chk("mid rst in_ready", in_ready, 1);
    chk("mid rst count", ovf_count, 0);
    sb.delete();
    m_cnt = 0;
    m_stk = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle();
    drive(16'hFF9C, 1'b1, 8'h9C, 1'b0);
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule

// File: doc/sign_narrow.md
SIGN_NARROW -- requirements
Module: sign_narrow

Interface
REQ-001 Parameter IN_SIZE, default 16, SHALL set the width of the wide signed input.
REQ-002 Parameter OUT_SIZE, default 8, SHALL set the width of the narrow signed output; OUT_SIZE < IN_SIZE.
REQ-003 Port clk, input, 1: the only clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port in_valid, input, 1: the source presents a value.
REQ-006 Port in_ready, output, 1: the block accepts a value this cycle.
REQ-007 Port in_data, input, IN_SIZE: signed two's-complement value to narrow.
REQ-008 Port sat_en, input, 1: 1 = saturate on overflow; 0 = truncate; sampled with each accepted value.
REQ-009 Port out_valid, output, 1: out_data and out_ovf are valid.
REQ-010 Port out_ready, input, 1: the sink consumes the output this cycle.
REQ-011 Port out_data, output, OUT_SIZE: narrowed value.
REQ-012 Port out_ovf, output, 1: the value in out_data overflowed OUT_SIZE.
REQ-013 Port ovf_clr, input, 1: synchronous clear of ovf_sticky and ovf_count.
REQ-014 Port ovf_sticky, output, 1: at least one overflow has been accepted since the last clear or reset.
REQ-015 Port ovf_count, output, 8: count of accepted overflowing values, saturating at 255.

Function
REQ-016 Accept SHALL occur when in_valid && in_ready; consume SHALL occur when out_valid && out_ready.
REQ-017 Storage SHALL be a 2-entry FIFO of {out_data, out_ovf} entries with an occupancy count of 0..2.
REQ-018 in_ready SHALL be (count < 2), decoded from registers only, with no combinational path from out_ready.
REQ-019 out_valid SHALL be (count != 0); out_data and out_ovf SHALL come from the head entry.
REQ-020 Latency SHALL be 1 cycle: a value accepted at edge N appears on the outputs after edge N.
REQ-021 Throughput SHALL be one value per cycle while out_ready is held high.
REQ-022 Overflow SHALL be detected when in_data[IN_SIZE-1:OUT_SIZE-1] is not all-equal.
REQ-023 Without overflow, the stored data SHALL be in_data[OUT_SIZE-1:0].
REQ-024 On overflow with sat_en=0, the stored data SHALL be in_data[OUT_SIZE-1:0] (wrap).
REQ-025 On overflow with sat_en=1, a non-negative input SHALL store 0x7F (max positive) and a negative input SHALL store 0x80 (min negative), generalised to OUT_SIZE.
REQ-026 Accept and consume in the same cycle SHALL leave count unchanged, and ordering SHALL be preserved.
REQ-027 At count=2, no accept SHALL occur even if a consume happens that cycle; in_ready rises on the following cycle.
REQ-028 At count=0, out_ready SHALL be ignored.
REQ-029 out_data and out_ovf SHALL stay stable while out_valid=1 and out_ready=0.
REQ-030 ovf_sticky SHALL set on an accepted overflow and clear on ovf_clr; an accepted overflow in the same cycle as ovf_clr SHALL leave it set.
REQ-031 ovf_count SHALL increment on an accepted overflow and hold at 255.
REQ-032 On ovf_clr, ovf_count SHALL go to 0, or to 1 if an accepted overflow coincides with it.
REQ-033 ovf_clr SHALL NOT affect FIFO contents.

Reset
REQ-034 While rst_n=0, all state SHALL clear immediately, independent of clk: count=0, out_valid=0, out_data=0, out_ovf=0, ovf_sticky=0, ovf_count=0.
REQ-035 in_ready SHALL read 1 during reset.
REQ-036 Reset asserted mid-stream SHALL discard all buffered entries.
REQ-037 The first accept SHALL occur on the first rising edge with rst_n=1.

Verification
REQ-038 Input 0x0012, then 0xFFF0, with sat_en=1 and out_ready=1 -> outputs 0x12/ovf=0, then 0xF0/ovf=0, each one cycle after its accept.
REQ-039 Input 0x0180 with sat_en=1 -> 0x7F/ovf=1; with sat_en=0 -> 0x80/ovf=1; input 0xFE00 with sat_en=1 -> 0x80/ovf=1; ovf_count=3 and ovf_sticky=1.
REQ-040 Hold out_ready=0 and stream A,B,C -> in_ready drops after 2 accepts and outputs stay at A; then raise out_ready -> A,B,C delivered in order, and C is accepted only after in_ready returns.
REQ-041 Send 300 overflowing values -> ovf_count holds 255; ovf_clr pulsed in the same cycle as an overflowing accept -> ovf_count=1 and ovf_sticky=1.
REQ-042 With 2 entries buffered, pulse rst_n low between clock edges -> out_valid=0, out_data=0 and in_ready=1 immediately; no stale data after release.
